aes_decrypt_iter: RTL and testbench

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_decrypt_iter.sv | 240 ++++++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
`timescale 1ns/1ps
// Purpose     : iterative AES InvCipher (AES-128/192/256), one round per clock,
//               with on-chip key expansion into a register file of round keys.
// Latency     : out_valid rises NR cycles after block acceptance; key expansion
//               takes 4*(NR+1)-NK cycles after key_load.
// Backpressure: one block in flight; in_ready is low outside READY, and the result
//               is held in HOLD until out_ready. No input buffering.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key_load, key       key capture pulse and cipher key (key byte 0 in the MSBs)
//   key_ready           round keys for the current key are available
//   in_valid/in_ready   ciphertext handshake, data_in (byte s[0,0] in [127:120])
//   out_valid/out_ready plaintext handshake, data_out (same byte order)
module aes_decrypt_iter #(
   parameter int NK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_load,
   input  logic [NK*32-1:0] key,
   output logic             key_ready,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     data_out
);

   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam int IW = 6;

   localparam logic [2:0] NOKEY = 3'd0;
   localparam logic [2:0] KEXP  = 3'd1;
   localparam logic [2:0] READY = 3'd2;
   localparam logic [2:0] ROUND = 3'd3;
   localparam logic [2:0] HOLD  = 3'd4;

   if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("aes_decrypt_iter: NK must be 4, 6 or 8");
   end

   // ---------------- GF(2^8) helpers ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 = (a^127)^2; maps 0 to 0 as the S-box needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
      return gmul(r, r);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] t;
      t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(t);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // ---------------- round transforms ----------------
   // Byte s[r,c] lives at [127-8*(4c+r) -: 8]; row r is rotated right by r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
         o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
         o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
         o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
      end
      return o;
   endfunction

   // ---------------- state ----------------
   logic [2:0]    state_q, state_d;
   logic [127:0]  st_q, st_d;
   logic [3:0]    rnd_q, rnd_d;
   logic [IW-1:0] kidx_q, kidx_d;   // index of the next key word to generate
   logic [2:0]    kmod_q, kmod_d;   // kidx_q mod NK, tracked incrementally
   logic [7:0]    rcon_q, rcon_d;
   logic [31:0]   w_q [NW];

   logic          kload, key_we, kexp_we;
   logic [3:0]    rk_sel;
   logic [IW-1:0] rk_base;
   logic [127:0]  rk, ark, round_out;
   logic [31:0]   prev_w, far_w, temp_w, new_w;

   // In READY the round-key port points at rk[NR] for the initial whitening.
   assign rk_sel    = (state_q == READY) ? 4'(NR) : rnd_q;
   assign rk_base   = IW'({rk_sel, 2'b00});
   assign rk        = {w_q[rk_base], w_q[rk_base + IW'(1)],
                       w_q[rk_base + IW'(2)], w_q[rk_base + IW'(3)]};
   assign ark       = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk;
   assign round_out = (rnd_q == 4'd0) ? ark : inv_mix_columns(ark);

   assign prev_w = w_q[kidx_q - IW'(1)];
   assign far_w  = w_q[kidx_q - IW'(NK)];

   always_comb begin
      temp_w = prev_w;
      if (kmod_q == 3'd0)
         temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h000000};
      else if (NK == 8 && kmod_q == 3'd4)
         temp_w = sub_word(prev_w);
      new_w = far_w ^ temp_w;
   end

   // A key_load is only honoured when no block is in flight; in HOLD that
   // means the result is being handed off in this same cycle.
   assign kload = key_load && (state_q == NOKEY || state_q == READY ||
                               (state_q == HOLD && out_ready));

   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      rnd_d   = rnd_q;
      kidx_d  = kidx_q;
      kmod_d  = kmod_q;
      rcon_d  = rcon_q;
      key_we  = 1'b0;
      kexp_we = 1'b0;
      case (state_q)
         KEXP: begin
            kexp_we = 1'b1;
            kidx_d  = kidx_q + IW'(1);
            kmod_d  = (kmod_q == 3'(NK-1)) ? 3'd0 : kmod_q + 3'd1;
            if (kmod_q == 3'd0) rcon_d = xtime(rcon_q);
            if (kidx_q == IW'(NW-1)) state_d = READY;
         end
         READY: begin
            if (!key_load && in_valid) begin
               st_d    = data_in ^ rk;
               rnd_d   = 4'(NR-1);
               state_d = ROUND;
            end
         end
         ROUND: begin
            st_d = round_out;
            if (rnd_q == 4'd0) state_d = HOLD;
            else               rnd_d   = rnd_q - 4'd1;
         end
         HOLD: begin
            if (out_ready) state_d = READY;
         end
         default: state_d = NOKEY;
      endcase
      if (kload) begin
         state_d = KEXP;
         key_we  = 1'b1;
         kidx_d  = IW'(NK);
         kmod_d  = 3'd0;
         rcon_d  = 8'h01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= NOKEY;
         st_q    <= '0;
         rnd_q   <= '0;
         kidx_q  <= '0;
         kmod_q  <= '0;
         rcon_q  <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         rnd_q   <= rnd_d;
         kidx_q  <= kidx_d;
         kmod_q  <= kmod_d;
         rcon_q  <= rcon_d;
      end
   end

   // Round-key storage needs no reset: it is only read after a full expansion.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (key_we) begin
            for (int i = 0; i < NK; i++) w_q[i] <= key[NK*32-1-32*i -: 32];
         end else if (kexp_we) begin
            w_q[kidx_q] <= new_w;
         end
      end
   end

   assign key_ready = (state_q == READY) || (state_q == ROUND) || (state_q == HOLD);
   assign in_ready  = (state_q == READY) && !key_load;
   assign out_valid = (state_q == HOLD);
   assign data_out  = out_valid ? st_q : '0;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
`timescale 1ns/1ps
// Bench for aes_decrypt_iter: three instances (NK=4/6/8) driven with known
// vectors; a scoreboard queue holds expected plaintext and the cycle on which
// out_valid must rise, and a monitor process checks every presented output.
module tb_aes_decrypt_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, ordy;
   logic [2:0]     kl, ivl, krdy, irdy, ovl;
   logic [127:0]   din  [3];
   logic [127:0]   dout [3];
   logic [127:0]   key4;
   logic [191:0]   key6;
   logic [255:0]   key8;

   aes_decrypt_iter #(.NK(4)) u_dut4 (
      .clk(clk), .rst(rst), .key_load(kl[0]), .key(key4), .key_ready(krdy[0]),
      .in_valid(ivl[0]), .in_ready(irdy[0]), .data_in(din[0]),
      .out_valid(ovl[0]), .out_ready(ordy), .data_out(dout[0]));
   aes_decrypt_iter #(.NK(6)) u_dut6 (
      .clk(clk), .rst(rst), .key_load(kl[1]), .key(key6), .key_ready(krdy[1]),
      .in_valid(ivl[1]), .in_ready(irdy[1]), .data_in(din[1]),
      .out_valid(ovl[1]), .out_ready(ordy), .data_out(dout[1]));
   aes_decrypt_iter #(.NK(8)) u_dut8 (
      .clk(clk), .rst(rst), .key_load(kl[2]), .key(key8), .key_ready(krdy[2]),
      .in_valid(ivl[2]), .in_ready(irdy[2]), .data_in(din[2]),
      .out_valid(ovl[2]), .out_ready(ordy), .data_out(dout[2]));

   typedef struct {
      int           dut;
      logic [127:0] pt;
      longint       due;
   } exp_t;

   exp_t   exp_q[$];
   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   logic [2:0] ov_prev = 3'b000;

   localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
   localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KSP  = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
   localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;

   logic [127:0] sp_ct [5];
   logic [127:0] sp_pt [5];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int nr_of(input int d);
      return 10 + 2 * d;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkn(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: samples 1 ns after the falling edge so stimulus driven on that
   // edge has settled.
   always @(negedge clk) begin
      #1;
      for (int d = 0; d < 3; d++) begin
         if (ovl[d]) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out dut%0d: got %h expected no output", d, dout[d]);
            end else if (exp_q[0].dut != d) begin
               checks++; errors++;
               $display("FAIL out_dut: got dut%0d expected dut%0d", d, exp_q[0].dut);
            end else begin
               if (!ov_prev[d]) chkn("out_latency_cycle", cyc, exp_q[0].due);
               chk("data_out", dout[d], exp_q[0].pt);
               if (ordy) void'(exp_q.pop_front());
            end
         end
         ov_prev[d] = ovl[d];
      end
   end

   // Called on the falling edge right after the key_load capture edge.
   task automatic kexp_wait(input int d);
      int n;
      chk("key_ready_drop", krdy[d], 1'b0);
      n = 0;
      while (!krdy[d] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chkn("kexp_cycles", n, 4 * (nr_of(d) + 1) - (4 + 2 * d));
   endtask

   task automatic load_key(input int d, input logic [255:0] k);
      @(negedge clk);
      if (d == 0) key4 = k[255:128];
      else if (d == 1) key6 = k[255:64];
      else key8 = k;
      kl[d] = 1'b1;
      @(negedge clk);
      kl[d] = 1'b0;
      kexp_wait(d);
   endtask

   task automatic send(input int d, input logic [127:0] ct, input logic [127:0] pt,
                       output longint acc);
      int t;
      exp_t e;
      @(negedge clk);
      ivl[d] = 1'b1;
      din[d] = ct;
      t = 0;
      while (!irdy[d] && t < 200) begin
         @(negedge clk);
         t++;
      end
      acc = cyc;
      if (!irdy[d]) begin
         chk("accept_timeout", irdy[d], 1'b1);
      end else begin
         e.dut = d;
         e.pt  = pt;
         e.due = cyc + 1 + nr_of(d);
         exp_q.push_back(e);
      end
      @(negedge clk);
      ivl[d] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chkn("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint acc, prev_acc;
      sp_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97; sp_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      sp_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf; sp_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      sp_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688; sp_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      sp_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4; sp_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
      sp_ct[4] = 128'h3925841d02dc09fbdc118597196a0b32; sp_pt[4] = 128'h3243f6a8885a308d313198a2e0370734;

      rst = 1'b1; ordy = 1'b1; kl = '0; ivl = '0;
      key4 = '0; key6 = '0; key8 = '0;
      for (int d = 0; d < 3; d++) din[d] = '0;
      repeat (3) @(negedge clk);
      chk("rst_key_ready", krdy[0], 1'b0);
      chk("rst_in_ready", irdy[0], 1'b0);
      chk("rst_out_valid", ovl[0], 1'b0);
      chk("rst_data_out", dout[0], 128'h0);
      rst = 1'b0;

      // No key yet: offered blocks are refused.
      ivl[0] = 1'b1;
      din[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      repeat (5) begin
         @(negedge clk);
         chk("nokey_in_ready", irdy[0], 1'b0);
         chk("nokey_key_ready", krdy[0], 1'b0);
      end
      ivl[0] = 1'b0;

      // AES-128 known answer.
      load_key(0, K128);
      send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT0, acc);
      wait_idle();

      // Held output: consumer stalls 20 cycles while a new block is offered.
      ordy = 1'b0;
      send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT0, acc);
      for (int n = 0; n < 50 && !ovl[0]; n++) @(negedge clk);
      chk("hold_reached", ovl[0], 1'b1);
      ivl[0] = 1'b1;
      din[0] = 128'h0123456789abcdef0123456789abcdef;
      repeat (20) begin
         @(negedge clk);
         chk("hold_in_ready", irdy[0], 1'b0);
         chk("hold_out_valid", ovl[0], 1'b1);
      end
      ivl[0] = 1'b0;
      ordy = 1'b1;
      wait_idle();

      // key_load and in_valid together in READY: the key wins.
      @(negedge clk);
      key4 = KSP[255:128];
      kl[0] = 1'b1;
      ivl[0] = 1'b1;
      din[0] = sp_ct[0];
      #1;
      chk("kl_iv_in_ready", irdy[0], 1'b0);
      @(negedge clk);
      kl[0] = 1'b0;
      ivl[0] = 1'b0;
      kexp_wait(0);

      // Back-to-back blocks under the new key, no re-expansion in between.
      prev_acc = 0;
      for (int i = 0; i < 5; i++) begin
         send(0, sp_ct[i], sp_pt[i], acc);
         if (i > 0) chkn("b2b_spacing", acc - prev_acc, 12);
         prev_acc = acc;
      end
      wait_idle();

      // Reset in the middle of a decryption.
      send(0, sp_ct[4], sp_pt[4], acc);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", ovl[0], 1'b0);
      chk("midrst_key_ready", krdy[0], 1'b0);
      chk("midrst_in_ready", irdy[0], 1'b0);
      rst = 1'b0;
      exp_q.delete();
      ivl[0] = 1'b1;
      din[0] = sp_ct[1];
      repeat (10) begin
         @(negedge clk);
         chk("postrst_in_ready", irdy[0], 1'b0);
      end
      ivl[0] = 1'b0;
      load_key(0, K128);
      send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT0, acc);
      wait_idle();

      // AES-192 and AES-256 known answers.
      load_key(1, K192);
      send(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT0, acc);
      wait_idle();
      load_key(2, K256);
      send(2, 128'h8ea2b7ca516745bfeafc49904b496089, PT0, acc);
      wait_idle();

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
